matrix_result_streamer: RTL and testbench
=========================================

# matrix_result_streamer

Serializes the 3×3 product matrix from the matrix multiplier into a byte stream for the board's output link, such as a UART transmitter or display driver. It sits directly downstream of the multiplier. It captures the packed 144-bit result on the rising edge of the multiplier's done flag, then emits 18 bytes over a valid/ready handshake. Each element goes out little-endian, in element order 0..8.

## Interface
Parameters:
- ELEM_W, 16: width of one result element in bits; must be a multiple of 8.
- N_ELEM, 9: number of result elements (3×3).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mult_done  in  1  done flag from the multiplier; level, may stay high indefinitely.
- result  in  N_ELEM*ELEM_W  packed product; element e occupies bits [e*ELEM_W +: ELEM_W]; element 0 is row 0 col 0, row-major.
- tx_data  out  8  current output byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte; a transfer occurs on an edge where tx_valid && tx_ready.
- busy  out  1  high from capture until the final byte is accepted.
- stream_done  out  1  one-cycle pulse after the final byte is accepted.
- overrun  out  1  sticky; set when a mult_done rising edge arrives while busy.

## Operation
- Edge detect:
  - A register done_q (reset 0) samples mult_done each cycle.
  - rise = mult_done && !done_q.
  - mult_done high coming out of reset counts as a rise.
- FSM states: IDLE, SEND, CKSUM (present only with the macro).
- IDLE, on rise:
  - Load result into the shadow register.
  - Clear byte_idx to 0 and clear overrun.
  - Go to SEND.
- SEND:
  - tx_data = byte byte_idx of the shadow register, i.e. shadow[byte_idx*8 +: 8].
  - Byte 0 is the low byte of element 0; byte 17 is the high byte of element 8.
  - On each transfer, byte_idx increments.
  - On transfer of byte N_ELEM*ELEM_W/8−1: go to CKSUM if enabled, else to IDLE with a stream_done pulse.
- CKSUM: tx_data = checksum. On transfer, go to IDLE with a stream_done pulse.
- rise while not IDLE: the result is ignored, the shadow register is unchanged, and overrun is set. This includes a rise on the same edge as the final transfer.
- The shadow register isolates the stream from changes on result after capture.
- Reset mid-stream: return to IDLE immediately and drop tx_valid. No stream_done pulse; the partial stream is abandoned.

## Timing
- Reset values: tx_data 0, tx_valid 0, busy 0, stream_done 0, overrun 0; done_q 0, byte_idx 0, state IDLE.
- Capture edge k (rise sampled): tx_valid and busy are high from edge k on, with byte 0 presented.
- With tx_ready held high: one byte per cycle. Byte i is accepted at edge k+1+i. The final byte (index 17) is accepted at edge k+18.
- After the final transfer edge: tx_valid=0, busy=0, stream_done=1 for exactly one cycle.
- A new rise is accepted no earlier than the edge after the final transfer.
- Handshake rules:
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer, except on reset.
  - tx_ready while tx_valid=0 has no effect.
- All outputs are registered; there is no combinational path from tx_ready to tx_valid.

## Configuration
- RESULT_STREAM_CKSUM_EN defined:
  - A 19th byte follows the payload.
  - checksum = 8-bit sum mod 256 of all payload bytes, accumulated on each payload transfer and cleared at capture.
  - stream_done and busy fall after the checksum transfer, at edge k+19 with ready held high.
- Undefined: 18-byte stream only; no checksum logic or CKSUM state.

## Test plan
- A=identity, B=1..9 (result elements 1..9), tx_ready=1:
  - Bytes are 01 00 02 00 … 09 00 on consecutive cycles.
  - stream_done pulses once; busy is high for exactly 18 cycles.
  - With the macro, a 19th byte 0x2D (45) follows.
- Backpressure: tx_ready toggled 1,0,0,1 repeating on the above stream.
  - tx_data is stable during stalls; no byte is dropped or duplicated.
  - The 18 bytes arrive in the same order.
- Elements 0xFFFF ×9: every byte is FF.
  - With the macro, checksum = (18×255) mod 256 = 0xEE.
- Sticky mult_done: held high for 100 cycles after a single rise.
  - Exactly one stream is produced; no retrigger.
  - Dropping mult_done and raising it again starts a second stream.
- Overrun: a second rise at byte 5 of the stream.
  - overrun=1; the stream completes with the original data.
  - The next accepted capture clears overrun.
- Reset asserted at byte 7: all outputs return to their reset values asynchronously, with no stream_done pulse. A rise after reset release streams from byte 0.

Source files
------------

// File: rtl/matrix_result_streamer_if.sv
// matrix_result_streamer_if: byte-stream valid/ready handshake between the streamer and its sink.
interface matrix_result_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: captures the packed multiplier result on a done rise and streams it LSB-byte first.
// Define RESULT_STREAM_CKSUM_EN to append an 8-bit additive checksum byte after the payload.
module matrix_result_streamer #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mult_done,
  input  logic [N_ELEM*ELEM_W-1:0]   result,
  matrix_result_streamer_if.master   tx,
  output logic                       busy,
  output logic                       stream_done,
  output logic                       overrun
);
  localparam int NB = N_ELEM * ELEM_W / 8;
  localparam int IW = $clog2(NB + 1);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);
`ifdef RESULT_STREAM_CKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CKSUM} state_e;
  logic [7:0] cks_q, cks_d;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_e;
`endif
  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NB-1:0][7:0]    shadow_q, shadow_d;
  logic                  done_q, ovr_q, ovr_d, sd_q, sd_d;
  logic                  rise, xfer;
  logic [7:0]            cur_byte;
  assign rise     = mult_done && !done_q;
  assign cur_byte = shadow_q[idx_q];
  assign xfer     = tx.tx_valid && tx.tx_ready;
  assign tx.tx_valid = state_q != IDLE;
  assign busy        = state_q != IDLE;
  assign stream_done = sd_q;
  assign overrun     = ovr_q;
`ifdef RESULT_STREAM_CKSUM_EN
  assign tx.tx_data = state_q == CKSUM ? cks_q : state_q == SEND ? cur_byte : 8'h00;
`else
  assign tx.tx_data = state_q == SEND ? cur_byte : 8'h00;
`endif
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    ovr_d    = ovr_q;
    sd_d     = 1'b0;
`ifdef RESULT_STREAM_CKSUM_EN
    cks_d    = cks_q;
`endif
    case (state_q)
      IDLE: if (rise) begin
        shadow_d = result;
        idx_d    = '0;
        ovr_d    = 1'b0;
        state_d  = SEND;
`ifdef RESULT_STREAM_CKSUM_EN
        cks_d    = 8'h00;
`endif
      end
      SEND: if (xfer) begin
        idx_d = idx_q + IW'(1);
`ifdef RESULT_STREAM_CKSUM_EN
        cks_d = cks_q + cur_byte;
        if (idx_q == LAST) state_d = CKSUM;
`else
        if (idx_q == LAST) begin
          state_d = IDLE;
          sd_d    = 1'b1;
        end
`endif
      end
`ifdef RESULT_STREAM_CKSUM_EN
      CKSUM: if (xfer) begin
        state_d = IDLE;
        sd_d    = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    // A rise that arrives while a stream is in flight, even on its last edge, is dropped and flagged.
    if (rise && state_q != IDLE) ovr_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      sd_q     <= 1'b0;
`ifdef RESULT_STREAM_CKSUM_EN
      cks_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      done_q   <= mult_done;
      ovr_q    <= ovr_d;
      sd_q     <= sd_d;
`ifdef RESULT_STREAM_CKSUM_EN
      cks_q    <= cks_d;
`endif
    end
  end
endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer: scoreboard bench; expected bytes are queued at capture and popped on each transfer.
module tb_matrix_result_streamer;
`ifdef RESULT_STREAM_CKSUM_EN
  localparam int NBYTES = 19;
`else
  localparam int NBYTES = 18;
`endif
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mult_done = 1'b0;
  logic [143:0] result = '0;
  logic         busy, stream_done, overrun;
  matrix_result_streamer_if sif();
  matrix_result_streamer #(.ELEM_W(16), .N_ELEM(9)) dut (
    .clk(clk), .rst_n(rst_n), .mult_done(mult_done), .result(result),
    .tx(sif.master), .busy(busy), .stream_done(stream_done), .overrun(overrun)
  );
  always #5 clk = ~clk;
  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int sd_cnt, busy_cyc;

  task automatic push(input logic [143:0] r);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 18; i++) begin
      exp_q.push_back(r[i*8 +: 8]);
      s = s + r[i*8 +: 8];
    end
`ifdef RESULT_STREAM_CKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  task automatic capture(input logic [143:0] r);
    @(posedge clk);
    #1;
    result = r;
    mult_done = 1'b1;
    push(r);
  endtask

  function automatic logic [143:0] rand_result();
    logic [143:0] r;
    for (int e = 0; e < 9; e++) r[e*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  // Runs the sink side: drives tx_ready (mode 0 = always, 1 = 1,0,0,1 pattern) and scores every transfer.
  task automatic drain(input int mode, input bit keep, input int ovr_at);
    logic [7:0] pd, e;
    bit stall;
    sd_cnt = 0;
    busy_cyc = 0;
    stall = 1'b0;
    pd = 8'h00;
    for (int c = 0; c < 400 && sd_cnt == 0; c++) begin
      @(posedge clk);
      #1;
      if (c == 0 && !keep) mult_done = 1'b0;
      if (c == ovr_at) begin
        mult_done = 1'b1;
        result = ~result;
      end
      sif.tx_ready = (mode == 0) ? 1'b1 : (c % 4 == 0 || c % 4 == 3);
      @(negedge clk);
      busy_cyc += int'(busy);
      sd_cnt += int'(stream_done);
      if (stall) begin
        total++;
        if (!sif.tx_valid || sif.tx_data !== pd) begin
          bad++;
          $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", sif.tx_valid, sif.tx_data, pd);
        end
      end
      stall = sif.tx_valid && !sif.tx_ready;
      pd = sif.tx_data;
      if (sif.tx_valid && sif.tx_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_byte: got %h with nothing expected", sif.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (sif.tx_data !== e) begin
            bad++;
            $display("FAIL byte: got %h required %h", sif.tx_data, e);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0 || sd_cnt != 1) begin
      bad++;
      $display("FAIL stream_end: left=%0d stream_done=%0d required left=0 stream_done=1", exp_q.size(), sd_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({sif.tx_data, sif.tx_valid, busy, stream_done, overrun} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: data=%h valid=%b busy=%b done=%b ovr=%b required all 0",
               sif.tx_data, sif.tx_valid, busy, stream_done, overrun);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (sif.tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: valid=%b busy=%b required 0 0", sif.tx_valid, busy);
    end
  endtask

  task automatic test_identity();
    logic [143:0] r;
    for (int e = 0; e < 9; e++) r[e*16 +: 16] = 16'(e + 1);
    capture(r);
    drain(0, 1'b0, -1);
    total++;
    if (busy_cyc != NBYTES) begin
      bad++;
      $display("FAIL busy_cycles: got %0d required %0d", busy_cyc, NBYTES);
    end
    @(negedge clk);
    total++;
    if (stream_done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: stream_done=%b required 0", stream_done);
    end
  endtask

  task automatic test_backpressure();
    logic [143:0] r;
    for (int e = 0; e < 9; e++) r[e*16 +: 16] = 16'(e + 1);
    capture(r);
    drain(1, 1'b0, -1);
  endtask

  task automatic test_all_ones();
    capture({144{1'b1}});
    drain(0, 1'b0, -1);
  endtask

  task automatic test_sticky_done();
    int n;
    capture(rand_result());
    drain(0, 1'b1, -1);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (sif.tx_valid || busy || stream_done) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL sticky_retrigger: active cycles=%0d required 0", n);
    end
    mult_done = 1'b0;
    capture(rand_result());
    drain(0, 1'b0, -1);
  endtask

  task automatic test_overrun();
    capture(rand_result());
    drain(0, 1'b0, 5);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: overrun=%b required 1", overrun);
    end
    mult_done = 1'b0;
    capture(rand_result());
    drain(0, 1'b0, -1);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: overrun=%b required 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic [143:0] r;
    int n;
    r = rand_result();
    capture(r);
    exp_q.delete();
    sif.tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    #3;
    total++;
    if (sif.tx_data !== r[63:56]) begin
      bad++;
      $display("FAIL byte7_before_reset: got %h required %h", sif.tx_data, r[63:56]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({sif.tx_data, sif.tx_valid, busy, stream_done, overrun} !== 12'h000) begin
      bad++;
      $display("FAIL async_reset: data=%h valid=%b busy=%b done=%b ovr=%b required all 0",
               sif.tx_data, sif.tx_valid, busy, stream_done, overrun);
    end
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (stream_done || sif.tx_valid) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL reset_quiet: active cycles=%0d required 0", n);
    end
    // mult_done is still high, so leaving reset must count as a fresh rise.
    push(r);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain(0, 1'b0, -1);
  endtask

  initial begin
    sif.tx_ready = 1'b0;
    test_reset();
    test_identity();
    test_backpressure();
    test_all_ones();
    test_sticky_done();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
